control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Sequencer that drives the UL8 internal bus: it generates bus_sel and the per-register load strobes consumed by bus_mux and the akku/pc/x/y/ar/ir registers.
- Reads back the IR value and runs a fetch/execute micro-step FSM, one bus transfer per clock.
- Sits beside the datapath in top.
- Bus source map: 0 akku, 1 pc, 2 x, 3 y, 4 ar, 5 ir, 6 memory data at address ar, 7 pc+1 (external incrementer).

Parameters:
HALT_ON_ILLEGAL, 0, 1 = an undefined opcode enters HALT; 0 = an undefined opcode executes as NOP.

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
ir  in  8  current IR register contents (bus_in_5)
bus_sel  out  3  bus source select
akku_load  out  1  load akku from bus at next edge
pc_load  out  1  load pc
x_load  out  1  load x
y_load  out  1  load y
ar_load  out  1  load ar
ir_load  out  1  load ir
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse on decode of an undefined opcode
step  out  3  current micro-step, for debug

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values (rst_n low): state=FETCH, step=0, bus_sel=0, all *_load=0, halted=0, illegal=0. Outputs are forced to these values for as long as rst_n is low.
- Outputs are a combinational decode of the registered state, step and ir. At most one *_load is high in any cycle; this is checked by an assertion.
- Instruction format: ir[7:4] opcode, ir[3:2] dst, ir[1:0] src.
- Register codes (dst and src): 0 akku, 1 x, 2 y, 3 ar. These map to bus_sel 0, 2, 3, 4.
- States: FETCH, EXEC, HALT. step counts micro-steps within a state and returns to 0 on every state change.
- FETCH (3 cycles):
  - F0: bus_sel=1, ar_load.
  - F1: bus_sel=6, ir_load.
  - F2: bus_sel=7, pc_load. Then go to EXEC, step 0.
- ir is sampled only in EXEC; its value in FETCH is ignored.
- EXEC by opcode; each micro-step is one cycle, and the last step returns to FETCH F0:
  - 0x0 NOP: E0 with no load.
  - 0x1 MOV: E0 bus_sel=src code, dst_load. If src==dst, no load is asserted (still 1 cycle).
  - 0x2 LDI: E0 bus_sel=1, ar_load; E1 bus_sel=6, dst_load; E2 bus_sel=7, pc_load.
  - 0x3 LD: E0 bus_sel=1, ar_load; E1 bus_sel=6, ar_load; E2 bus_sel=6, dst_load; E3 bus_sel=7, pc_load.
    - Operand is taken from memory at the address held in the byte after the opcode.
    - If dst==ar, E2 overwrites ar; this is permitted.
  - 0x4 JMP: E0 bus_sel=1, ar_load; E1 bus_sel=6, pc_load. No pc increment.
  - 0xF HLT: E0 with no load, then go to HALT.
  - Others: illegal pulses during E0. If HALT_ON_ILLEGAL=1 go to HALT; otherwise act as NOP.
- Total cycles per instruction: NOP 4, MOV 4, LDI 6, LD 7, JMP 5, HLT 4 then stop.
- HALT: all loads 0, bus_sel=0, halted=1. HALT is left only by reset.
- step wraps only through the transitions above. An unreachable step value returns to FETCH F0.
- Reset mid-instruction: the in-flight instruction is abandoned immediately. After rst_n deasserts, the first active edge state is FETCH F0.

Decomposition:
- Package ul8_pkg holds:
  - the bus source codes (SRC_AKKU..SRC_INC);
  - the opcode constants;
  - the register codes;
  - the state enum (FETCH/EXEC/HALT);
  - the function mapping a register code to a bus_sel value.
- One sub-module, ul8_decode, is natural: it is combinational and maps opcode and step to {bus_sel, load vector, last_step, to_halt, illegal}.
- control_unit itself keeps only the state and step registers.

Test Plan:
- Release reset, hold ir=0x00 -> repeating 4-cycle pattern:
  - F0 sel1/ar;
  - F1 sel6/ir;
  - F2 sel7/pc;
  - E0 no load.
  - halted=0.
- ir=0x16 (MOV x<-y) -> in E0, bus_sel=3 and x_load=1 only. Next cycle is F0.
- ir=0x2C (LDI ar) -> E0 sel1/ar_load, E1 sel6/ar_load, E2 sel7/pc_load. 6 cycles total.
- ir=0x30 (LD akku) -> E0–E3 are sel1/ar, sel6/ar, sel6/akku, sel7/pc. 7 cycles total.
- ir=0x40 (JMP) -> E1 sel6/pc_load with no following increment; 5 cycles. ir=0xF0 -> after E0, halted=1 and loads stay 0 for 20 cycles.
- ir=0x70 -> with HALT_ON_ILLEGAL=0, a 1-cycle illegal pulse, then F0. With 1, illegal pulses, then halted=1. Assert rst_n low during LD E2 -> loads drop to 0 immediately, and the first cycle after release is F0.

Source files
------------

// File: rtl/ul8_pkg.sv
// Shared definitions for the UL8 sequencer: bus source codes, opcodes,
// register codes, FSM state type and the load-strobe vector.
package ul8_pkg;

   localparam logic [2:0] SRC_AKKU = 3'd0;
   localparam logic [2:0] SRC_PC   = 3'd1;
   localparam logic [2:0] SRC_X    = 3'd2;
   localparam logic [2:0] SRC_Y    = 3'd3;
   localparam logic [2:0] SRC_AR   = 3'd4;
   localparam logic [2:0] SRC_IR   = 3'd5;
   localparam logic [2:0] SRC_MEM  = 3'd6;
   localparam logic [2:0] SRC_INC  = 3'd7;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_MOV = 4'h1;
   localparam logic [3:0] OP_LDI = 4'h2;
   localparam logic [3:0] OP_LD  = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] REG_AKKU = 2'd0;
   localparam logic [1:0] REG_X    = 2'd1;
   localparam logic [1:0] REG_Y    = 2'd2;
   localparam logic [1:0] REG_AR   = 2'd3;

   // Last micro-step of the fetch sequence (F2); it hands over to EXEC.
   localparam logic [2:0] STEP_F_LAST = 3'd2;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   typedef struct packed {
      logic akku;
      logic pc;
      logic x;
      logic y;
      logic ar;
      logic ir;
   } loads_t;

   localparam loads_t LD_NONE = '0;

   function automatic logic [2:0] reg_to_sel(input logic [1:0] code);
      case (code)
         REG_AKKU: return SRC_AKKU;
         REG_X:    return SRC_X;
         REG_Y:    return SRC_Y;
         default:  return SRC_AR;
      endcase
   endfunction

   function automatic loads_t reg_to_load(input logic [1:0] code);
      loads_t l;
      l = LD_NONE;
      case (code)
         REG_AKKU: l.akku = 1'b1;
         REG_X:    l.x    = 1'b1;
         REG_Y:    l.y    = 1'b1;
         default:  l.ar   = 1'b1;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/ul8_decode.sv
// Combinational micro-op decoder: maps state, micro-step and IR to the bus
// select, load strobes and sequencing hints consumed by control_unit.
module ul8_decode
   import ul8_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  state_t     i_state,
   input  logic [2:0] i_step,
   input  logic [7:0] i_ir,
   output logic [2:0] o_bus_sel,
   output loads_t     o_loads,
   output logic       o_last_step,
   output logic       o_to_halt,
   output logic       o_illegal
);

   logic [3:0] w_opcode;
   logic [1:0] w_dst;
   logic [1:0] w_src;

   assign w_opcode = i_ir[7:4];
   assign w_dst    = i_ir[3:2];
   assign w_src    = i_ir[1:0];

   // NOTE: every output gets a default before the case so no path can leave
   // one unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      o_bus_sel   = SRC_AKKU;
      o_loads     = LD_NONE;
      o_last_step = 1'b1;
      o_to_halt   = 1'b0;
      o_illegal   = 1'b0;

      case (i_state)
         FETCH: begin
            case (i_step)
               3'd0: begin
                  o_bus_sel   = SRC_PC;
                  o_loads.ar  = 1'b1;
                  o_last_step = 1'b0;
               end
               3'd1: begin
                  o_bus_sel   = SRC_MEM;
                  o_loads.ir  = 1'b1;
                  o_last_step = 1'b0;
               end
               3'd2: begin
                  o_bus_sel  = SRC_INC;
                  o_loads.pc = 1'b1;
               end
               default: ;
            endcase
         end

         EXEC: begin
            case (w_opcode)
               OP_NOP: ;
               OP_MOV: begin
                  if (i_step == 3'd0) begin
                     o_bus_sel = reg_to_sel(w_src);
                     if (w_src != w_dst) o_loads = reg_to_load(w_dst);
                  end
               end
               OP_LDI: begin
                  case (i_step)
                     3'd0: begin
                        o_bus_sel   = SRC_PC;
                        o_loads.ar  = 1'b1;
                        o_last_step = 1'b0;
                     end
                     3'd1: begin
                        o_bus_sel   = SRC_MEM;
                        o_loads     = reg_to_load(w_dst);
                        o_last_step = 1'b0;
                     end
                     3'd2: begin
                        o_bus_sel  = SRC_INC;
                        o_loads.pc = 1'b1;
                     end
                     default: ;
                  endcase
               end
               OP_LD: begin
                  // Indirect: the operand byte is an address, reloaded into ar.
                  case (i_step)
                     3'd0: begin
                        o_bus_sel   = SRC_PC;
                        o_loads.ar  = 1'b1;
                        o_last_step = 1'b0;
                     end
                     3'd1: begin
                        o_bus_sel   = SRC_MEM;
                        o_loads.ar  = 1'b1;
                        o_last_step = 1'b0;
                     end
                     3'd2: begin
                        o_bus_sel   = SRC_MEM;
                        o_loads     = reg_to_load(w_dst);
                        o_last_step = 1'b0;
                     end
                     3'd3: begin
                        o_bus_sel  = SRC_INC;
                        o_loads.pc = 1'b1;
                     end
                     default: ;
                  endcase
               end
               OP_JMP: begin
                  case (i_step)
                     3'd0: begin
                        o_bus_sel   = SRC_PC;
                        o_loads.ar  = 1'b1;
                        o_last_step = 1'b0;
                     end
                     3'd1: begin
                        o_bus_sel  = SRC_MEM;
                        o_loads.pc = 1'b1;
                     end
                     default: ;
                  endcase
               end
               OP_HLT: o_to_halt = (i_step == 3'd0);
               default: begin
                  if (i_step == 3'd0) begin
                     o_illegal = 1'b1;
                     o_to_halt = HALT_ON_ILLEGAL;
                  end
               end
            endcase
         end

         HALT:    o_last_step = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// UL8 bus sequencer: holds the fetch/execute state and micro-step, and drives
// bus_sel plus one register load strobe per cycle from ul8_decode.
module control_unit
   import ul8_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ir,
   output logic [2:0] bus_sel,
   output logic       akku_load,
   output logic       pc_load,
   output logic       x_load,
   output logic       y_load,
   output logic       ar_load,
   output logic       ir_load,
   output logic       halted,
   output logic       illegal,
   output logic [2:0] step
);

   state_t     r_state;
   state_t     w_next_state;
   logic [2:0] r_step;
   logic [2:0] w_next_step;

   logic [2:0] w_sel;
   loads_t     w_loads;
   logic       w_last_step;
   logic       w_to_halt;
   logic       w_illegal;

   ul8_decode #(
      .HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)
   ) u_decode (
      .i_state    (r_state),
      .i_step     (r_step),
      .i_ir       (ir),
      .o_bus_sel  (w_sel),
      .o_loads    (w_loads),
      .o_last_step(w_last_step),
      .o_to_halt  (w_to_halt),
      .o_illegal  (w_illegal)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of the order the blocks are evaluated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
         r_step  <= 3'd0;
      end else begin
         r_state <= w_next_state;
         r_step  <= w_next_step;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_step  = 3'(r_step + 3'd1);
      case (r_state)
         FETCH: begin
            if (w_last_step) begin
               // Only a genuine F2 proceeds; a stray step value restarts fetch.
               w_next_state = (r_step == STEP_F_LAST) ? EXEC : FETCH;
               w_next_step  = 3'd0;
            end
         end
         EXEC: begin
            if (w_last_step) begin
               w_next_state = w_to_halt ? HALT : FETCH;
               w_next_step  = 3'd0;
            end
         end
         HALT: w_next_step = 3'd0;
         default: begin
            w_next_state = FETCH;
            w_next_step  = 3'd0;
         end
      endcase
   end

   // Outputs are gated by rst_n itself so they read idle for the whole reset.
   always_comb begin
      bus_sel   = SRC_AKKU;
      akku_load = 1'b0;
      pc_load   = 1'b0;
      x_load    = 1'b0;
      y_load    = 1'b0;
      ar_load   = 1'b0;
      ir_load   = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
      if (rst_n) begin
         bus_sel   = w_sel;
         akku_load = w_loads.akku;
         pc_load   = w_loads.pc;
         x_load    = w_loads.x;
         y_load    = w_loads.y;
         ar_load   = w_loads.ar;
         ir_load   = w_loads.ir;
         halted    = (r_state == HALT);
         illegal   = w_illegal;
      end
   end

   assign step = r_step;

   a_one_load : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({akku_load, pc_load, x_load, y_load, ar_load, ir_load}));

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-instruction micro-op table model
// predicts every cycle's outputs for directed and random instruction streams.
module tb_control_unit;

   localparam logic [5:0] L_NONE = 6'b000000;
   localparam logic [5:0] L_AKKU = 6'b100000;
   localparam logic [5:0] L_PC   = 6'b010000;
   localparam logic [5:0] L_X    = 6'b001000;
   localparam logic [5:0] L_Y    = 6'b000100;
   localparam logic [5:0] L_AR   = 6'b000010;
   localparam logic [5:0] L_IR   = 6'b000001;

   typedef struct packed {
      logic [2:0] sel;
      logic [5:0] ld;
      logic       halted;
      logic       illegal;
      logic [2:0] step;
   } cyc_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n0, rst_n1;
   logic [7:0] ir0, ir1;
   logic [2:0] sel0, sel1, step0, step1;
   logic [5:0] ld0, ld1;
   logic       halted0, halted1, illegal0, illegal1;

   control_unit #(.HALT_ON_ILLEGAL(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n0), .ir(ir0), .bus_sel(sel0),
      .akku_load(ld0[5]), .pc_load(ld0[4]), .x_load(ld0[3]), .y_load(ld0[2]),
      .ar_load(ld0[1]), .ir_load(ld0[0]),
      .halted(halted0), .illegal(illegal0), .step(step0)
   );

   control_unit #(.HALT_ON_ILLEGAL(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n1), .ir(ir1), .bus_sel(sel1),
      .akku_load(ld1[5]), .pc_load(ld1[4]), .x_load(ld1[3]), .y_load(ld1[2]),
      .ar_load(ld1[1]), .ir_load(ld1[0]),
      .halted(halted1), .illegal(illegal1), .step(step1)
   );

   int   checks = 0;
   int   errors = 0;
   cyc_t q[$];

   function automatic cyc_t mk(input logic [2:0] sel, input logic [5:0] ld,
                               input logic hlt, input logic ill, input logic [2:0] stp);
      cyc_t c;
      c.sel = sel; c.ld = ld; c.halted = hlt; c.illegal = ill; c.step = stp;
      return c;
   endfunction

   function automatic cyc_t observe(input int d);
      if (d == 0) return mk(sel0, ld0, halted0, illegal0, step0);
      return mk(sel1, ld1, halted1, illegal1, step1);
   endfunction

   task automatic check(input string tag, input cyc_t obs, input cyc_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed sel=%0d ld=%b halt=%b ill=%b step=%0d, expected sel=%0d ld=%b halt=%b ill=%b step=%0d",
                tag, obs.sel, obs.ld, obs.halted, obs.illegal, obs.step,
                exp.sel, exp.ld, exp.halted, exp.illegal, exp.step);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected cycle list for one instruction: fetch triple, then the execute steps.
   task automatic build(input int d, input logic [7:0] v, output bit halts);
      logic [2:0] rsel [4];
      logic [5:0] rld  [4];
      logic [3:0] op;
      logic [1:0] dst, src;
      rsel = '{3'd0, 3'd2, 3'd3, 3'd4};
      rld  = '{L_AKKU, L_X, L_Y, L_AR};
      op  = v[7:4];
      dst = v[3:2];
      src = v[1:0];
      halts = 1'b0;
      q.delete();
      q.push_back(mk(3'd1, L_AR, 1'b0, 1'b0, 3'd0));
      q.push_back(mk(3'd6, L_IR, 1'b0, 1'b0, 3'd1));
      q.push_back(mk(3'd7, L_PC, 1'b0, 1'b0, 3'd2));
      case (op)
         4'h0: q.push_back(mk(3'd0, L_NONE, 1'b0, 1'b0, 3'd0));
         4'h1: q.push_back(mk(rsel[src], (src == dst) ? L_NONE : rld[dst], 1'b0, 1'b0, 3'd0));
         4'h2: begin
            q.push_back(mk(3'd1, L_AR,     1'b0, 1'b0, 3'd0));
            q.push_back(mk(3'd6, rld[dst], 1'b0, 1'b0, 3'd1));
            q.push_back(mk(3'd7, L_PC,     1'b0, 1'b0, 3'd2));
         end
         4'h3: begin
            q.push_back(mk(3'd1, L_AR,     1'b0, 1'b0, 3'd0));
            q.push_back(mk(3'd6, L_AR,     1'b0, 1'b0, 3'd1));
            q.push_back(mk(3'd6, rld[dst], 1'b0, 1'b0, 3'd2));
            q.push_back(mk(3'd7, L_PC,     1'b0, 1'b0, 3'd3));
         end
         4'h4: begin
            q.push_back(mk(3'd1, L_AR, 1'b0, 1'b0, 3'd0));
            q.push_back(mk(3'd6, L_PC, 1'b0, 1'b0, 3'd1));
         end
         4'hF: begin
            q.push_back(mk(3'd0, L_NONE, 1'b0, 1'b0, 3'd0));
            halts = 1'b1;
         end
         default: begin
            q.push_back(mk(3'd0, L_NONE, 1'b0, 1'b1, 3'd0));
            halts = (d == 1);
         end
      endcase
   endtask

   task automatic run(input int d, input logic [7:0] v, output bit halts);
      if (d == 0) ir0 = v; else ir1 = v;
      #1;
      build(d, v, halts);
      foreach (q[i]) begin
         check($sformatf("d%0d_ir%02h_c%0d", d, v, i), observe(d), q[i]);
         tick();
      end
   endtask

   task automatic expect_halted(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         if (d == 0) ir0 = 8'($urandom);
         #1;
         check($sformatf("d%0d_halt_c%0d", d, i), observe(d), mk(3'd0, L_NONE, 1'b1, 1'b0, 3'd0));
         tick();
      end
   endtask

   initial begin
      bit         h;
      logic [7:0] v;
      logic [3:0] op;
      logic [3:0] regs;
      rst_n0 = 1'b0;
      rst_n1 = 1'b0;
      ir0    = 8'h00;
      ir1    = 8'h00;

      #3;
      check("reset_d0", observe(0), mk(3'd0, L_NONE, 1'b0, 1'b0, 3'd0));
      check("reset_d1", observe(1), mk(3'd0, L_NONE, 1'b0, 1'b0, 3'd0));
      tick();
      tick();
      check("reset_held_d0", observe(0), mk(3'd0, L_NONE, 1'b0, 1'b0, 3'd0));
      rst_n0 = 1'b1;

      for (int i = 0; i < 3; i++) run(0, 8'h00, h);
      run(0, 8'h16, h);
      run(0, 8'h2C, h);
      run(0, 8'h30, h);
      run(0, 8'h40, h);
      run(0, 8'h70, h);
      run(0, 8'h15, h);

      for (int i = 0; i < 40; i++) begin
         op   = 4'($urandom_range(0, 14));
         regs = 4'($urandom);
         v    = {op, regs};
         run(0, v, h);
      end

      // Reset asserted during LD E2 must abandon the instruction at once.
      ir0 = 8'h30;
      #1;
      build(0, 8'h30, h);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("ld_pre_reset_c%0d", i), observe(0), q[i]);
         if (i < 5) tick();
      end
      rst_n0 = 1'b0;
      #1;
      check("ld_reset_now", observe(0), mk(3'd0, L_NONE, 1'b0, 1'b0, 3'd0));
      tick();
      check("ld_reset_hold", observe(0), mk(3'd0, L_NONE, 1'b0, 1'b0, 3'd0));
      tick();
      rst_n0 = 1'b1;
      run(0, 8'h24, h);

      run(0, 8'hF0, h);
      expect_halted(0, 20);

      rst_n1 = 1'b1;
      run(1, 8'h00, h);
      run(1, 8'h70, h);
      check("d1_illegal_halts_model", mk(3'd0, L_NONE, h, 1'b0, 3'd0), observe(1));
      expect_halted(1, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
